// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// with a registered response slot per port. Optional grant counters: ALU_ARB_STAT_EN.
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              r0_req_valid_i,
  output logic              r0_req_ready_o,
  input  logic [2:0]        r0_ctrl_i,
  input  logic [DATA_W-1:0] r0_op1_i,
  input  logic [DATA_W-1:0] r0_op2_i,
  input  logic [TAG_W-1:0]  r0_tag_i,
  output logic              r0_resp_valid_o,
  input  logic              r0_resp_ready_i,
  output logic [DATA_W-1:0] r0_resp_data_o,
  output logic [TAG_W-1:0]  r0_resp_tag_o,
  input  logic              r1_req_valid_i,
  output logic              r1_req_ready_o,
  input  logic [2:0]        r1_ctrl_i,
  input  logic [DATA_W-1:0] r1_op1_i,
  input  logic [DATA_W-1:0] r1_op2_i,
  input  logic [TAG_W-1:0]  r1_tag_i,
  output logic              r1_resp_valid_o,
  input  logic              r1_resp_ready_i,
  output logic [DATA_W-1:0] r1_resp_data_o,
  output logic [TAG_W-1:0]  r1_resp_tag_o,
  output logic [2:0]        alu_ctrl_o,
  output logic [DATA_W-1:0] alu_data1_o,
  output logic [DATA_W-1:0] alu_data2_o,
  input  logic [DATA_W-1:0] alu_res_i
`ifdef ALU_ARB_STAT_EN
  ,
  output logic [15:0]       r0_grant_cnt_o,
  output logic [15:0]       r1_grant_cnt_o
`endif
);

  logic              r0_valid_q, r0_valid_d;
  logic [DATA_W-1:0] r0_data_q, r0_data_d;
  logic [TAG_W-1:0]  r0_tag_q, r0_tag_d;
  logic              r1_valid_q, r1_valid_d;
  logic [DATA_W-1:0] r1_data_q, r1_data_d;
  logic [TAG_W-1:0]  r1_tag_q, r1_tag_d;
  logic              last_q, last_d;
  logic              elig0, elig1, grant0, grant1;

  // A slot may be refilled in the same cycle its current result drains.
  always_comb begin
    elig0  = r0_req_valid_i && (!r0_valid_q || r0_resp_ready_i) && !flush_i && rst_i;
    elig1  = r1_req_valid_i && (!r1_valid_q || r1_resp_ready_i) && !flush_i && rst_i;
    grant0 = elig0 && (!elig1 || last_q);
    grant1 = elig1 && (!elig0 || !last_q);
  end

  always_comb begin
    alu_ctrl_o  = 3'b000;
    alu_data1_o = '0;
    alu_data2_o = '0;
    if (grant0) begin
      alu_ctrl_o  = r0_ctrl_i;
      alu_data1_o = r0_op1_i;
      alu_data2_o = r0_op2_i;
    end else if (grant1) begin
      alu_ctrl_o  = r1_ctrl_i;
      alu_data1_o = r1_op1_i;
      alu_data2_o = r1_op2_i;
    end
  end

  always_comb begin
    r0_valid_d = r0_valid_q;
    r0_data_d  = r0_data_q;
    r0_tag_d   = r0_tag_q;
    r1_valid_d = r1_valid_q;
    r1_data_d  = r1_data_q;
    r1_tag_d   = r1_tag_q;
    last_d     = last_q;
    if (flush_i) begin
      r0_valid_d = 1'b0;
      r1_valid_d = 1'b0;
    end else begin
      if (grant0) begin
        r0_valid_d = 1'b1;
        r0_data_d  = alu_res_i;
        r0_tag_d   = r0_tag_i;
        last_d     = 1'b0;
      end else if (r0_resp_ready_i) begin
        r0_valid_d = 1'b0;
      end
      if (grant1) begin
        r1_valid_d = 1'b1;
        r1_data_d  = alu_res_i;
        r1_tag_d   = r1_tag_i;
        last_d     = 1'b1;
      end else if (r1_resp_ready_i) begin
        r1_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r0_valid_q <= 1'b0;
      r0_data_q  <= '0;
      r0_tag_q   <= '0;
      r1_valid_q <= 1'b0;
      r1_data_q  <= '0;
      r1_tag_q   <= '0;
      last_q     <= 1'b1;
    end else begin
      r0_valid_q <= r0_valid_d;
      r0_data_q  <= r0_data_d;
      r0_tag_q   <= r0_tag_d;
      r1_valid_q <= r1_valid_d;
      r1_data_q  <= r1_data_d;
      r1_tag_q   <= r1_tag_d;
      last_q     <= last_d;
    end
  end

  assign r0_req_ready_o  = grant0;
  assign r1_req_ready_o  = grant1;
  assign r0_resp_valid_o = r0_valid_q;
  assign r0_resp_data_o  = r0_data_q;
  assign r0_resp_tag_o   = r0_tag_q;
  assign r1_resp_valid_o = r1_valid_q;
  assign r1_resp_data_o  = r1_data_q;
  assign r1_resp_tag_o   = r1_tag_q;

`ifdef ALU_ARB_STAT_EN
  logic [15:0] r0_grant_cnt_q, r0_grant_cnt_d;
  logic [15:0] r1_grant_cnt_q, r1_grant_cnt_d;

  // Saturating counters; flush has no effect on them.
  always_comb begin
    r0_grant_cnt_d = r0_grant_cnt_q;
    r1_grant_cnt_d = r1_grant_cnt_q;
    if (grant0 && r0_grant_cnt_q != 16'hFFFF) r0_grant_cnt_d = r0_grant_cnt_q + 16'd1;
    if (grant1 && r1_grant_cnt_q != 16'hFFFF) r1_grant_cnt_d = r1_grant_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r0_grant_cnt_q <= '0;
      r1_grant_cnt_q <= '0;
    end else begin
      r0_grant_cnt_q <= r0_grant_cnt_d;
      r1_grant_cnt_q <= r1_grant_cnt_d;
    end
  end

  assign r0_grant_cnt_o = r0_grant_cnt_q;
  assign r1_grant_cnt_o = r1_grant_cnt_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: expected responses are queued per port at
// each observed request handshake and checked by a separate monitor.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst_i, flush_i;
  logic        r0_req_valid_i, r0_req_ready_o, r0_resp_valid_o, r0_resp_ready_i;
  logic [2:0]  r0_ctrl_i;
  logic [31:0] r0_op1_i, r0_op2_i, r0_resp_data_o;
  logic [3:0]  r0_tag_i, r0_resp_tag_o;
  logic        r1_req_valid_i, r1_req_ready_o, r1_resp_valid_o, r1_resp_ready_i;
  logic [2:0]  r1_ctrl_i;
  logic [31:0] r1_op1_i, r1_op2_i, r1_resp_data_o;
  logic [3:0]  r1_tag_i, r1_resp_tag_o;
  logic [2:0]  alu_ctrl_o;
  logic [31:0] alu_data1_o, alu_data2_o, alu_res_i;
`ifdef ALU_ARB_STAT_EN
  logic [15:0] cnt0, cnt1;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [35:0] q0[$];
  logic [35:0] q1[$];

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(32), .TAG_W(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .r0_req_valid_i(r0_req_valid_i), .r0_req_ready_o(r0_req_ready_o),
    .r0_ctrl_i(r0_ctrl_i), .r0_op1_i(r0_op1_i), .r0_op2_i(r0_op2_i), .r0_tag_i(r0_tag_i),
    .r0_resp_valid_o(r0_resp_valid_o), .r0_resp_ready_i(r0_resp_ready_i),
    .r0_resp_data_o(r0_resp_data_o), .r0_resp_tag_o(r0_resp_tag_o),
    .r1_req_valid_i(r1_req_valid_i), .r1_req_ready_o(r1_req_ready_o),
    .r1_ctrl_i(r1_ctrl_i), .r1_op1_i(r1_op1_i), .r1_op2_i(r1_op2_i), .r1_tag_i(r1_tag_i),
    .r1_resp_valid_o(r1_resp_valid_o), .r1_resp_ready_i(r1_resp_ready_i),
    .r1_resp_data_o(r1_resp_data_o), .r1_resp_tag_o(r1_resp_tag_o),
    .alu_ctrl_o(alu_ctrl_o), .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o),
    .alu_res_i(alu_res_i)
`ifdef ALU_ARB_STAT_EN
    , .r0_grant_cnt_o(cnt0), .r1_grant_cnt_o(cnt1)
`endif
  );

  // Reference ALU sitting behind the arbiter.
  always_comb begin
    case (alu_ctrl_o)
      3'b000:  alu_res_i = alu_data1_o + alu_data2_o;
      3'b001:  alu_res_i = alu_data1_o - alu_data2_o;
      3'b010:  alu_res_i = alu_data1_o & alu_data2_o;
      3'b011:  alu_res_i = alu_data1_o ^ alu_data2_o;
      3'b100:  alu_res_i = alu_data1_o << alu_data2_o[4:0];
      3'b101:  alu_res_i = alu_data1_o * alu_data2_o;
      3'b110:  alu_res_i = $signed(alu_data1_o) >>> alu_data2_o[4:0];
      default: alu_res_i = alu_data1_o + alu_data2_o;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a response retires only when it is really consumed.
  initial begin
    logic [35:0] e;
    forever begin
      @(negedge clk);
      if (rst_i && !flush_i && r0_resp_valid_o && r0_resp_ready_i) begin
        if (q0.size() == 0) check("r0_unexpected_resp", 1, 0);
        else begin
          e = q0.pop_front();
          check("r0_resp_data", r0_resp_data_o, e[35:4]);
          check("r0_resp_tag", r0_resp_tag_o, e[3:0]);
        end
      end
      if (rst_i && !flush_i && r1_resp_valid_o && r1_resp_ready_i) begin
        if (q1.size() == 0) check("r1_unexpected_resp", 1, 0);
        else begin
          e = q1.pop_front();
          check("r1_resp_data", r1_resp_data_o, e[35:4]);
          check("r1_resp_tag", r1_resp_tag_o, e[3:0]);
        end
      end
    end
  end

  task automatic set0(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] t);
    r0_req_valid_i = v; r0_ctrl_i = c; r0_op1_i = a; r0_op2_i = b; r0_tag_i = t;
  endtask

  task automatic set1(input logic v, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] t);
    r1_req_valid_i = v; r1_ctrl_i = c; r1_op1_i = a; r1_op2_i = b; r1_tag_i = t;
  endtask

  // Sample grants at the falling edge and queue the result each accepted request must yield.
  task automatic tick(input logic eg0, input logic eg1, input logic [31:0] ed0, input logic [3:0] et0,
                      input logic [31:0] ed1, input logic [3:0] et1);
    @(negedge clk);
    check("r0_req_ready", r0_req_ready_o, eg0);
    check("r1_req_ready", r1_req_ready_o, eg1);
    if (r0_req_valid_i && r0_req_ready_o) q0.push_back({ed0, et0});
    if (r1_req_valid_i && r1_req_ready_o) q1.push_back({ed1, et1});
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tick(0, 0, 0, 0, 0, 0);
    adv();
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    adv();
    adv();
    q0.delete();
    q1.delete();
    @(negedge clk);
    check("rst_r0_valid", r0_resp_valid_o, 0);
    check("rst_r1_valid", r1_resp_valid_o, 0);
    check("rst_r0_data", {r0_resp_data_o, r0_resp_tag_o}, 0);
    check("rst_r1_data", {r1_resp_data_o, r1_resp_tag_o}, 0);
    check("rst_alu_ctrl", {alu_ctrl_o, alu_data1_o, alu_data2_o}, 0);
    adv();
    rst_i = 1'b1;
  endtask

  initial begin
    rst_i = 1'b0; flush_i = 1'b0;
    r0_resp_ready_i = 1'b1; r1_resp_ready_i = 1'b1;
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    #1;
    do_reset();

    // Single add on port 0: accepted at once, answered one cycle later.
    set0(1, 3'b000, 5, 7, 3);
    tick(1, 0, 12, 3, 0, 0);
    check("t1_alu_ctrl", alu_ctrl_o, 3'b000);
    check("t1_alu_op1", alu_data1_o, 5);
    adv();
    set0(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    check("t1_latency_valid", r0_resp_valid_o, 1);
    check("t1_latency_data", r0_resp_data_o, 12);
    adv();
    idle();

    // Continuous contention alternates starting with port 0.
    do_reset();
    set0(1, 3'b001, 10, 3, 1);
    set1(1, 3'b101, 6, 7, 2);
    for (int i = 0; i < 2; i++) begin
      tick(1, 0, 7, 1, 42, 2); adv();
      tick(0, 1, 7, 1, 42, 2); adv();
    end

    // Backpressure on port 1 while port 0 takes every cycle.
    set0(1, 3'b000, 1, 2, 7);
    set1(1, 3'b110, 32'hFFFF_FFF0, 2, 5);
    tick(1, 0, 3, 7, 32'hFFFF_FFFC, 5); adv();
    tick(0, 1, 3, 7, 32'hFFFF_FFFC, 5); adv();
    r1_resp_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1, 0, 3, 7, 32'hFFFF_FFFC, 5);
      check("t3_hold_valid", r1_resp_valid_o, 1);
      check("t3_hold_data", r1_resp_data_o, 32'hFFFF_FFFC);
      check("t3_hold_tag", r1_resp_tag_o, 5);
      adv();
    end
    r1_resp_ready_i = 1'b1;
    tick(0, 1, 3, 7, 32'hFFFF_FFFC, 5); adv();
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    check("t3_resume_valid", r1_resp_valid_o, 1);
    adv();
    idle();

    // Flush with both slots full and both requests pending.
    r0_resp_ready_i = 1'b0; r1_resp_ready_i = 1'b0;
    set0(1, 3'b011, 32'hF0, 32'hFF, 9);
    set1(1, 3'b100, 1, 4, 10);
    tick(1, 0, 32'h0F, 9, 16, 10); adv();
    tick(0, 1, 32'h0F, 9, 16, 10); adv();
    tick(0, 0, 32'h0F, 9, 16, 10); adv();
    flush_i = 1'b1;
    r0_resp_ready_i = 1'b1; r1_resp_ready_i = 1'b1;
    tick(0, 0, 32'h0F, 9, 16, 10);
    check("t4_flush_alu_ctrl", {alu_ctrl_o, alu_data1_o, alu_data2_o}, 0);
    adv();
    q0.delete(); q1.delete();
    flush_i = 1'b0;
    tick(1, 0, 32'h0F, 9, 16, 10);
    check("t4_flush_r0_valid", r0_resp_valid_o, 0);
    check("t4_flush_r1_valid", r1_resp_valid_o, 0);
    check("t4_flush_r0_data_kept", r0_resp_data_o, 32'h0F);
    check("t4_flush_r1_data_kept", r1_resp_data_o, 16);
    adv();
    tick(0, 1, 32'h0F, 9, 16, 10); adv();
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    idle();
    idle();

    // Reset mid-stream; the pointer was left favouring port 1 beforehand.
    r0_resp_ready_i = 1'b0; r1_resp_ready_i = 1'b0;
    set1(1, 3'b010, 32'hF, 32'h3, 4);
    tick(0, 1, 0, 0, 3, 4); adv();
    set1(0, 0, 0, 0, 0);
    set0(1, 3'b000, 100, 23, 6);
    tick(1, 0, 123, 6, 0, 0); adv();
    rst_i = 1'b0;
    r0_resp_ready_i = 1'b1; r1_resp_ready_i = 1'b1;
    set1(1, 3'b010, 32'hF, 32'h3, 4);
    tick(0, 0, 123, 6, 3, 4); adv();
    q0.delete(); q1.delete();
    rst_i = 1'b1;
    tick(1, 0, 123, 6, 3, 4);
    check("t5_rst_r0_valid", r0_resp_valid_o, 0);
    check("t5_rst_r1_valid", r1_resp_valid_o, 0);
    check("t5_rst_r0_data", {r0_resp_data_o, r0_resp_tag_o}, 0);
    check("t5_rst_r1_data", {r1_resp_data_o, r1_resp_tag_o}, 0);
    adv();
    tick(0, 1, 123, 6, 3, 4); adv();
    set0(0, 0, 0, 0, 0);
    set1(0, 0, 0, 0, 0);
    idle();
    idle();

`ifdef ALU_ARB_STAT_EN
    do_reset();
    set0(1, 3'b000, 1, 1, 0);
    for (int i = 0; i < 5; i++) begin tick(1, 0, 2, 0, 0, 0); adv(); end
    set0(0, 0, 0, 0, 0);
    set1(1, 3'b010, 32'hF, 32'h3, 1);
    for (int i = 0; i < 3; i++) begin tick(0, 1, 0, 0, 3, 1); adv(); end
    set1(0, 0, 0, 0, 0);
    idle();
    @(negedge clk);
    check("t6_cnt0", cnt0, 5);
    check("t6_cnt1", cnt1, 3);
    adv();
    force dut.r0_grant_cnt_q = 16'hFFFF;
    #1;
    release dut.r0_grant_cnt_q;
    set0(1, 3'b000, 1, 1, 0);
    tick(1, 0, 2, 0, 0, 0); adv();
    set0(0, 0, 0, 0, 0);
    idle();
    @(negedge clk);
    check("t6_cnt0_sat", cnt0, 16'hFFFF);
    adv();
`endif

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
